image_scanner: RTL

IMAGE_SCANNER -- requirements
Module: image_scanner

---
 rtl/image_scan_pkg.sv | 15 +
 rtl/axis_counter.sv | 35 +++
 rtl/image_scanner.sv | 114 +++++++++++
 3 files changed

// File: rtl/image_scan_pkg.sv
// image_scan_pkg: shared definitions for the raster scanner.
//   scan_state_t : controller states (IDLE, SCAN, DONE)
//   DEF_H_W/V_W  : default column/row counter widths
package image_scan_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } scan_state_t;

  localparam int DEF_H_W = 4;
  localparam int DEF_V_W = 4;

endpackage

// File: rtl/axis_counter.sv
// axis_counter: one raster axis (column or row) position counter.
// Ports:
//   clk, nrst : clock, async active-low reset
//   clear     : synchronous force to 0 (highest priority)
//   load      : synchronous start-of-frame reset to 0
//   inc       : advance one position; wraps to 0 when at the limit
//   lim       : last valid index on this axis
//   count     : current index
//   at_lim    : count == lim (combinational)
module axis_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         nrst,
  input  logic         clear,
  input  logic         load,
  input  logic         inc,
  input  logic [W-1:0] lim,
  output logic [W-1:0] count,
  output logic         at_lim
);

  logic [W-1:0] r_count;

  assign count  = r_count;
  assign at_lim = (r_count == lim);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst)       r_count <= '0;
    else if (clear)  r_count <= '0;
    else if (load)   r_count <= '0;
    else if (inc)    r_count <= at_lim ? '0 : r_count + W'(1);
  end

endmodule

// File: rtl/image_scanner.sv
// image_scanner: raster-order pixel coordinate generator.
// Ports:
//   clk, nrst       : clock, async active-low reset
//   start           : begin a frame from IDLE (limits latched here)
//   enable          : advance one pixel per cycle while scanning (consumer ready)
//   clear           : synchronous abort to IDLE, overrides everything else
//   continuous      : 1 = wrap frames back-to-back, 0 = single frame then DONE
//   h_max, v_max    : last column / row index, sampled only at start
//   x, y            : current pixel coordinate
//   valid           : x/y is a live pixel (SCAN state)
//   line_end        : live pixel is the last column
//   frame_end       : live pixel is the last pixel of the frame
//   done            : one-cycle pulse after a single-frame scan completes
module image_scanner
  import image_scan_pkg::*;
#(
  parameter int H_W = DEF_H_W,
  parameter int V_W = DEF_V_W
) (
  input  logic           clk,
  input  logic           nrst,
  input  logic           start,
  input  logic           enable,
  input  logic           clear,
  input  logic           continuous,
  input  logic [H_W-1:0] h_max,
  input  logic [V_W-1:0] v_max,
  output logic [H_W-1:0] x,
  output logic [V_W-1:0] y,
  output logic           valid,
  output logic           line_end,
  output logic           frame_end,
  output logic           done
);

  scan_state_t    r_state;
  logic [H_W-1:0] r_h_lim;
  logic [V_W-1:0] r_v_lim;
  logic           r_cont;
  logic           r_done;

  logic w_x_at_lim, w_y_at_lim;
  logic w_load, w_cnt_clr, w_x_inc, w_y_inc, w_last_single;

  assign valid     = (r_state == SCAN);
  assign line_end  = valid & w_x_at_lim;
  assign frame_end = line_end & w_y_at_lim;
  assign done      = r_done;

  assign w_load = (r_state == IDLE) & start;
  // Leaving DONE returns the coordinates to the origin so IDLE always shows (0,0).
  assign w_cnt_clr = clear | (r_state == DONE);
  // Final pixel of a single frame: counters freeze so DONE still shows (h_lim, v_lim).
  assign w_last_single = frame_end & ~r_cont;
  assign w_x_inc = valid & enable & ~w_last_single;
  // Row advances as an enable off the column wrap, same clock.
  assign w_y_inc = w_x_inc & w_x_at_lim;

  axis_counter #(.W(H_W)) u_col (
    .clk    (clk),
    .nrst   (nrst),
    .clear  (w_cnt_clr),
    .load   (w_load),
    .inc    (w_x_inc),
    .lim    (r_h_lim),
    .count  (x),
    .at_lim (w_x_at_lim)
  );

  axis_counter #(.W(V_W)) u_row (
    .clk    (clk),
    .nrst   (nrst),
    .clear  (w_cnt_clr),
    .load   (w_load),
    .inc    (w_y_inc),
    .lim    (r_v_lim),
    .count  (y),
    .at_lim (w_y_at_lim)
  );

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state <= IDLE;
      r_h_lim <= '0;
      r_v_lim <= '0;
      r_cont  <= 1'b0;
      r_done  <= 1'b0;
    end else if (clear) begin
      r_state <= IDLE;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_h_lim <= h_max;
            r_v_lim <= v_max;
            r_cont  <= continuous;
            r_state <= SCAN;
          end
        end
        SCAN: begin
          if (enable && w_last_single) begin
            r_state <= DONE;
            r_done  <= 1'b1;
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
